// File: rtl/alu_pkg.sv
// Shared ALU types: result bundle, data width and default buffer depth.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int ALU_RES_DEPTH = 4;

    typedef struct packed {
        logic             c;
        logic [ALU_W-1:0] z;
    } alu_res_t;

    function automatic logic alu_res_par(alu_res_t r);
        return ^r;
    endfunction

endpackage

// File: rtl/alu_res_mem.sv
// Register-array storage for the ALU result buffer.
// Synchronous write port, asynchronous read port, no reset on contents.
module alu_res_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 9,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// In-order result FIFO between the ALU and its consumer, push/stop handshake.
// Define ALU_RES_PARITY_EN to store a per-entry even-parity bit and add parout.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = ALU_RES_DEPTH,
    parameter int CNTW  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pushin,
    input  logic                       cin,
    input  logic [ALU_W-1:0]           zin,
    output logic                       stopout,
    output logic                       pushout,
    output logic                       cout,
    output logic [ALU_W-1:0]           z,
`ifdef ALU_RES_PARITY_EN
    output logic                       parout,
`endif
    input  logic                       stopin,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [CNTW-1:0]            carry_cnt,
    output logic                       drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int RW = $bits(alu_res_t);
`ifdef ALU_RES_PARITY_EN
    localparam int EW = RW + 1;
`else
    localparam int EW = RW;
`endif

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CNTW-1:0] carry_cnt_q, carry_cnt_d;
    logic            drop_err_q, drop_err_d;

    logic            accept;
    logic            release_en;
    alu_res_t        wr_res;
    alu_res_t        rd_res;
    logic [EW-1:0]   wdata;
    logic [EW-1:0]   rdata;

    // Flags come only from registered level so no input reaches an output.
    assign stopout    = (level_q == LW'(DEPTH));
    assign pushout    = (level_q != '0);
    assign accept     = pushin & ~stopout;
    assign release_en = pushout & ~stopin;

    assign wr_res = '{c: cin, z: zin};
`ifdef ALU_RES_PARITY_EN
    assign wdata = {alu_res_par(wr_res), wr_res};
`else
    assign wdata = wr_res;
`endif

    alu_res_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Storage is not reset, so the head is masked while empty.
    assign rd_res = alu_res_t'(rdata[RW-1:0]);
    assign cout   = pushout & rd_res.c;
    assign z      = pushout ? rd_res.z : '0;
`ifdef ALU_RES_PARITY_EN
    assign parout = pushout & rdata[EW-1];
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        carry_cnt_d = carry_cnt_q;
        drop_err_d  = drop_err_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (release_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({accept, release_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (accept && cin && (carry_cnt_q != '1)) begin
            carry_cnt_d = carry_cnt_q + CNTW'(1);
        end
        if (pushin && stopout) begin
            drop_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            carry_cnt_q <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            carry_cnt_q <= carry_cnt_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign level     = level_q;
    assign carry_cnt = carry_cnt_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer with an in-order scoreboard.
// Build with ALU_RES_PARITY_EN to also cover parout.
module tb_alu_result_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pushin;
    logic       cin;
    logic [7:0] zin;
    logic       stopout;
    logic       pushout;
    logic       cout;
    logic [7:0] z;
`ifdef ALU_RES_PARITY_EN
    logic       parout;
`endif
    logic       stopin;
    logic [2:0] level;
    logic [7:0] carry_cnt;
    logic       drop_err;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [8:0] sb_q[$];
    logic [8:0] exp_e;

    always #5 clk = ~clk;

    alu_result_buffer #(.DEPTH(4), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pushin    (pushin),
        .cin       (cin),
        .zin       (zin),
        .stopout   (stopout),
        .pushout   (pushout),
        .cout      (cout),
        .z         (z),
`ifdef ALU_RES_PARITY_EN
        .parout    (parout),
`endif
        .stopin    (stopin),
        .level     (level),
        .carry_cnt (carry_cnt),
        .drop_err  (drop_err)
    );

    // Scoreboard monitor: sampled mid-cycle, predicts the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
        end else if (mon_en) begin
            checks++;
            if (level !== 3'(sb_q.size())) begin
                failures++;
                $display("FAIL sb_level got=%0d exp=%0d", level, sb_q.size());
            end
            checks++;
            if (pushout !== (sb_q.size() != 0)) begin
                failures++;
                $display("FAIL sb_pushout got=%b exp=%b", pushout, sb_q.size() != 0);
            end
            if (pushout && !stopin && sb_q.size() != 0) begin
                exp_e = sb_q.pop_front();
                checks++;
                if ({cout, z} !== exp_e) begin
                    failures++;
                    $display("FAIL sb_data got=%b/%h exp=%b/%h", cout, z, exp_e[8], exp_e[7:0]);
                end
            end
            if (pushin && sb_q.size() < 4) begin
                sb_q.push_back({cin, zin});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        pushin = 1'b0;
        cin    = 1'b0;
        zin    = 8'h00;
        stopin = 1'b0;
        tick();
        tick();
        checks++;
        if ({level, pushout, stopout, cout, z, carry_cnt, drop_err} !== 22'h0) begin
            failures++;
            $display("FAIL reset_state got lvl=%0d po=%b so=%b c=%b z=%h cc=%0d de=%b exp all zero",
                     level, pushout, stopout, cout, z, carry_cnt, drop_err);
        end
`ifdef ALU_RES_PARITY_EN
        checks++;
        if (parout !== 1'b0) begin
            failures++;
            $display("FAIL reset_parout got=%b exp=0", parout);
        end
`endif
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        pushin = 1'b1;
        cin    = 1'b0;
        zin    = 8'h3C;
        tick();
        pushin = 1'b0;
        checks++;
        if ({pushout, cout, z, level} !== {1'b1, 1'b0, 8'h3C, 3'd1}) begin
            failures++;
            $display("FAIL single got po=%b c=%b z=%h lvl=%0d exp po=1 c=0 z=3c lvl=1",
                     pushout, cout, z, level);
        end
        tick();
        checks++;
        if (level !== 3'd0) begin
            failures++;
            $display("FAIL single_drain got=%0d exp=0", level);
        end
    endtask

    task automatic test_fill_drop();
        stopin = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pushin = 1'b1;
            cin    = i[0];
            zin    = 8'(i);
            tick();
        end
        checks++;
        if ({stopout, level} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL full got so=%b lvl=%0d exp so=1 lvl=4", stopout, level);
        end
        cin = 1'b0;
        zin = 8'hFF;
        tick();
        pushin = 1'b0;
        checks++;
        if ({drop_err, level, z} !== {1'b1, 3'd4, 8'h01}) begin
            failures++;
            $display("FAIL drop got de=%b lvl=%0d z=%h exp de=1 lvl=4 z=01", drop_err, level, z);
        end
        stopin = 1'b0;
        tick();
        checks++;
        if ({stopout, level, z} !== {1'b0, 3'd3, 8'h02}) begin
            failures++;
            $display("FAIL unfull got so=%b lvl=%0d z=%h exp so=0 lvl=3 z=02", stopout, level, z);
        end
        repeat (3) tick();
        checks++;
        if ({pushout, level} !== {1'b0, 3'd0}) begin
            failures++;
            $display("FAIL drained got po=%b lvl=%0d exp po=0 lvl=0", pushout, level);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        stopin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pushin = 1'b1;
            cin    = i[0];
            zin    = 8'(8'h10 + i);
            tick();
            checks++;
            if (level !== 3'd1) begin
                failures++;
                $display("FAIL b2b_level i=%0d got=%0d exp=1", i, level);
            end
        end
        pushin = 1'b0;
        tick();
        checks++;
        if ({level, drop_err, carry_cnt} !== {3'd0, 1'b0, 8'd10}) begin
            failures++;
            $display("FAIL b2b_end got lvl=%0d de=%b cc=%0d exp lvl=0 de=0 cc=10",
                     level, drop_err, carry_cnt);
        end
    endtask

    task automatic test_carry_sat();
        do_reset();
        stopin = 1'b0;
        for (int i = 0; i < 300; i++) begin
            pushin = 1'b1;
            cin    = 1'b1;
            zin    = 8'(i);
            tick();
            if (i == 9) begin
                checks++;
                if (carry_cnt !== 8'd10) begin
                    failures++;
                    $display("FAIL carry_mid got=%0d exp=10", carry_cnt);
                end
            end
        end
        pushin = 1'b0;
        tick();
        checks++;
        if (carry_cnt !== 8'd255) begin
            failures++;
            $display("FAIL carry_sat got=%0d exp=255", carry_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stopin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pushin = 1'b1;
            cin    = 1'b1;
            zin    = 8'(8'h50 + i);
            tick();
        end
        pushin = 1'b0;
        checks++;
        if ({level, carry_cnt} !== {3'd3, 8'd3}) begin
            failures++;
            $display("FAIL pre_rst got lvl=%0d cc=%0d exp lvl=3 cc=3", level, carry_cnt);
        end
        do_reset();
        checks++;
        if ({level, pushout, stopout, drop_err, carry_cnt} !== 12'h0) begin
            failures++;
            $display("FAIL mid_rst got lvl=%0d po=%b so=%b de=%b cc=%0d exp all zero",
                     level, pushout, stopout, drop_err, carry_cnt);
        end
        stopin = 1'b0;
        pushin = 1'b1;
        cin    = 1'b0;
        zin    = 8'hA5;
        tick();
        pushin = 1'b0;
        checks++;
        if ({pushout, z, level} !== {1'b1, 8'hA5, 3'd1}) begin
            failures++;
            $display("FAIL post_rst got po=%b z=%h lvl=%0d exp po=1 z=a5 lvl=1", pushout, z, level);
        end
        tick();
        checks++;
        if (pushout !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_alone got po=%b exp=0", pushout);
        end
    endtask

`ifdef ALU_RES_PARITY_EN
    task automatic test_parity();
        do_reset();
        stopin = 1'b1;
        pushin = 1'b1;
        cin    = 1'b1;
        zin    = 8'h07;
        tick();
        pushin = 1'b0;
        checks++;
        if (parout !== 1'b0) begin
            failures++;
            $display("FAIL parity_c1 got=%b exp=0", parout);
        end
        stopin = 1'b0;
        tick();
        pushin = 1'b1;
        cin    = 1'b0;
        zin    = 8'h07;
        tick();
        pushin = 1'b0;
        checks++;
        if (parout !== 1'b1) begin
            failures++;
            $display("FAIL parity_c0 got=%b exp=1", parout);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_drop();
        test_back_to_back();
        test_carry_sat();
        test_reset_mid();
`ifdef ALU_RES_PARITY_EN
        test_parity();
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of the 8-bit ALU: captures each result (`cout`, `z`) the ALU pushes, stores it in a small in-order FIFO, and re-presents it to the next consumer with the same push/stop handshake. It decouples ALU throughput from consumer stalls by driving the ALU's `stopin`. It also keeps a saturating count of carry-out results for scoreboard cross-checks.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `CNTW`, default 8: width of carry counter.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `pushin`  in  1  from ALU `pushout`; result valid.
- `cin`  in  1  from ALU `cout`.
- `zin`  in  8  from ALU `z`.
- `stopout`  out  1  to ALU `stopin`; buffer cannot accept.
- `pushout`  out  1  head entry valid to consumer.
- `cout`  out  1  head entry carry.
- `z`  out  8  head entry result.
- `stopin`  in  1  consumer stall.
- `level`  out  $clog2(DEPTH+1)  current occupancy.
- `carry_cnt`  out  CNTW  count of accepted entries with `cin`=1, saturating.
- `drop_err`  out  1  sticky; push attempted while full.

## Operation
- Accept: `pushin`=1 and `stopout`=0 at the edge. The entry `{cin,zin}` is written at the tail, and the tail pointer increments modulo DEPTH.
- Release: `pushout`=1 and `stopin`=0 at the edge. The head pointer increments modulo DEPTH.
- `stopout` = (`level`==DEPTH). It is combinational from registered `level`.
- `pushout` = (`level`!=0). `cout`/`z` show the head entry and are held stable while `stopin`=1.
- Simultaneous accept and release: `level` is unchanged and both pointers advance. When full, accept is impossible that cycle even if a release occurs, because `stopout` does not look at `stopin`.
- `pushin`=1 while `stopout`=1: data is ignored and `drop_err` is set. `drop_err` is cleared only by reset.
- `carry_cnt` increments on every accept with `cin`=1. It holds at 2^CNTW-1.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by `level`, not by pointer compare.

## Timing
- Reset (rst=0 at edge): `level`=0, pointers=0, `pushout`=0, `stopout`=0, `cout`=0, `z`=8'h00, `carry_cnt`=0, `drop_err`=0. Storage contents are don't-care but are masked by `pushout`=0.
- Reset mid-operation flushes all entries with no drain. `pushout` is low the cycle after the reset edge.
- Latency is 1 cycle from accept to `pushout`, with no flow-through bypass when empty.
- Throughput is 1 entry/cycle sustained when not stalled.
- `stopout` rises the cycle after the accept that filled the buffer. It falls the cycle after the first release from full.
- No combinational path exists from `pushin` or `stopin` to any output.

## Configuration
- `ALU_RES_PARITY_EN` defined: each entry stores an extra even-parity bit computed at accept as ^{cin,zin}. The block adds output port `parout` (1 bit, head entry parity, reset 0). On a full-depth occupancy path, storage width is 10 bits per entry.
- Not defined: no `parout` port and 9-bit entries. All other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - `alu_res_t` packed struct {c, z[7:0]}.
  - `ALU_W`=8.
  - `ALU_RES_DEPTH`=4 as the default for `DEPTH`.
- One sub-module, `alu_res_mem`: a DEPTH×entry register array with a write port (en, addr, data) and an async read port. The control FSM (pointers, level, flags) stays in the top module.

## Test plan
- Reset, then push 8'h3C with cin=0 -> next cycle `pushout`=1, `z`=8'h3C, `cout`=0, `level`=1.
- With `stopin`=1, push 4 entries (8'h01..8'h04) -> `stopout`=1 after the 4th. A 5th push of 8'hFF sets `drop_err`=1 and `level` stays 4. After `stopin`=0, results drain as 01,02,03,04.
- Continuous push and pop every cycle for 20 cycles, exercising pointer wrap -> order is preserved, `level` is constant at 1, and there are no drops.
- Push 300 entries with cin=1 and CNTW=8 -> `carry_cnt`=255 (saturated).
- Fill to 3 entries, then assert rst=0 for one cycle -> `level`=0, `pushout`=0, `drop_err`=0, `carry_cnt`=0. The next push of 8'hA5 appears alone.
- `ALU_RES_PARITY_EN` build: push cin=1, z=8'h07 -> `parout`=0. Push cin=0, z=8'h07 -> `parout`=1.
